// File: rtl/board_pkg.sv
// Shared geometry, cell codes, FSM states and helpers
// for the board settle datapath.
package board_pkg;

   localparam int ROWS       = 8;
   localparam int COLS       = 8;
   localparam int CELL_W     = 3;
   localparam int NUM_COLORS = 6;
   localparam int LFSR_W     = 32;

   localparam int CELLS   = ROWS * COLS;
   localparam int BOARD_W = CELLS * CELL_W;
   localparam int COL_W   = ROWS * CELL_W;
   localparam int RCNT_W  = $clog2(ROWS + 1);
   localparam int CCNT_W  = $clog2(CELLS + 1);
   localparam int CIDX_W  = $clog2(COLS);
   localparam int CPOS_W  = $clog2(COLS + 1);

   localparam logic [CELL_W-1:0] EMPTY     = '0;
   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COLLAPSE,
      DONE
   } state_t;

   function automatic int idx(input int r, input int c);
      return r * COLS + c;
   endfunction

   function automatic logic [CELL_W-1:0] refill_code(
      input logic [7:0] b
   );
      logic [7:0] m;
      m = b % 8'(NUM_COLORS);
      return CELL_W'(m + 8'd1);
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_step(
      input logic [LFSR_W-1:0] s
   );
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/column_settle.sv
// One-column gravity: survivors drop toward row 0 in order,
// vacated top rows become EMPTY or take refill colours.
module column_settle
   import board_pkg::*;
(
   input  logic [COL_W-1:0]  col_in,
   input  logic [ROWS-1:0]   clr,
   input  logic              refill,
   input  logic [LFSR_W-1:0] rbits,
   output logic [COL_W-1:0]  col_out,
   output logic [RCNT_W-1:0] vac_cnt,
   output logic              changed
);

   logic [ROWS-1:0]   keep;
   logic [RCNT_W-1:0] pos [ROWS];
   logic [RCNT_W-1:0] nkeep;
   logic [COL_W-1:0]  comp;

   // pos[r] is the destination row of survivor r
   always_comb begin
      nkeep = '0;
      for (int r = 0; r < ROWS; r++) begin
         keep[r] = !clr[r] &&
                   (col_in[r*CELL_W +: CELL_W] != EMPTY);
         pos[r]  = nkeep;
         nkeep   = nkeep + RCNT_W'(keep[r]);
      end
   end

   always_comb begin
      comp = '0;
      for (int o = 0; o < ROWS; o++) begin
         for (int r = o; r < ROWS; r++) begin
            if (keep[r] && pos[r] == RCNT_W'(o)) begin
               comp[o*CELL_W +: CELL_W] =
                  col_in[r*CELL_W +: CELL_W];
            end
         end
      end
   end

   always_comb begin
      col_out = comp;
      for (int r = 0; r < ROWS; r++) begin
         if (RCNT_W'(r) >= nkeep) begin
            col_out[r*CELL_W +: CELL_W] = refill ?
               refill_code(rbits[(8*r)%LFSR_W +: 8]) : EMPTY;
         end
      end
   end

   assign vac_cnt = RCNT_W'(ROWS) - nkeep;
   assign changed = (comp != col_in) ||
                    (refill && (nkeep != RCNT_W'(ROWS)));

endmodule

// File: rtl/board_settle.sv
// Multi-cycle board settle: per-column gravity and refill,
// optional left collapse of empty columns, fixed latency.
module board_settle
   import board_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               seed_load,
   input  logic [LFSR_W-1:0]  seed,
   input  logic [BOARD_W-1:0] board_in,
   input  logic [CELLS-1:0]   clear_mask,
   output logic [BOARD_W-1:0] board_out,
   output logic               busy,
   output logic               done,
   output logic               moved,
   output logic [CCNT_W-1:0]  clear_count
);

   state_t state, state_nx;

   logic [CIDX_W-1:0]  col;
   logic [LFSR_W-1:0]  lfsr;
   logic [BOARD_W-1:0] work;
   logic [CELLS-1:0]   wmask;
   logic [1:0]         wmode;
   logic [CCNT_W-1:0]  cnt_acc;
   logic               mv_acc;
   logic               last_col;

   logic [COL_W-1:0]   col_in;
   logic [COL_W-1:0]   col_out;
   logic [ROWS-1:0]    col_clr;
   logic [RCNT_W-1:0]  vac_cnt;
   logic               col_chg;

   logic [COLS-1:0]    col_empty;
   logic [CPOS_W-1:0]  cpos [COLS];
   logic [BOARD_W-1:0] squeezed;
   logic [BOARD_W-1:0] settled;

   assign last_col = (col == CIDX_W'(COLS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (start) state_nx = SCAN;
         SCAN:     if (last_col) state_nx = COLLAPSE;
         COLLAPSE: state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      col_in  = '0;
      col_clr = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col == CIDX_W'(c)) begin
            for (int r = 0; r < ROWS; r++) begin
               col_in[r*CELL_W +: CELL_W] =
                  work[idx(r, c)*CELL_W +: CELL_W];
               col_clr[r] = wmask[idx(r, c)];
            end
         end
      end
   end

   column_settle u_col (
      .col_in  (col_in),
      .clr     (col_clr),
      .refill  (wmode[0]),
      .rbits   (lfsr),
      .col_out (col_out),
      .vac_cnt (vac_cnt),
      .changed (col_chg)
   );

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         col_empty[c] = 1'b1;
         for (int r = 0; r < ROWS; r++) begin
            if (work[idx(r, c)*CELL_W +: CELL_W] != EMPTY)
               col_empty[c] = 1'b0;
         end
      end
   end

   // cpos[c] is the destination column of a non-empty column c
   always_comb begin
      logic [CPOS_W-1:0] n;
      n = '0;
      for (int c = 0; c < COLS; c++) begin
         cpos[c] = n;
         n = n + CPOS_W'(!col_empty[c]);
      end
   end

   always_comb begin
      squeezed = '0;
      for (int o = 0; o < COLS; o++) begin
         for (int c = o; c < COLS; c++) begin
            if (!col_empty[c] && cpos[c] == CPOS_W'(o)) begin
               for (int r = 0; r < ROWS; r++) begin
                  squeezed[idx(r, o)*CELL_W +: CELL_W] =
                     work[idx(r, c)*CELL_W +: CELL_W];
               end
            end
         end
      end
   end

   assign settled = wmode[1] ? squeezed : work;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col         <= '0;
         lfsr        <= LFSR_W'(1);
         work        <= '0;
         wmask       <= '0;
         wmode       <= '0;
         cnt_acc     <= '0;
         mv_acc      <= 1'b0;
         board_out   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         moved       <= 1'b0;
         clear_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (seed_load)
                  lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
               if (start) begin
                  work    <= board_in;
                  wmask   <= clear_mask;
                  wmode   <= mode;
                  col     <= '0;
                  cnt_acc <= '0;
                  mv_acc  <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            SCAN: begin
               for (int c = 0; c < COLS; c++) begin
                  if (col == CIDX_W'(c)) begin
                     for (int r = 0; r < ROWS; r++) begin
                        work[idx(r, c)*CELL_W +: CELL_W] <=
                           col_out[r*CELL_W +: CELL_W];
                     end
                  end
               end
               lfsr    <= lfsr_step(lfsr);
               cnt_acc <= cnt_acc + CCNT_W'(vac_cnt);
               mv_acc  <= mv_acc | col_chg;
               col     <= last_col ? '0 : col + CIDX_W'(1);
            end
            // results land here so they are valid in the done cycle
            COLLAPSE: begin
               board_out   <= settled;
               moved       <= mv_acc | (settled != work);
               clear_count <= cnt_acc;
               done        <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
